// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, S-box table and GF(2^8) column helpers.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} aesState_t;

    function automatic int nkOf(int keyBits);
        return keyBits / 32;
    endfunction

    function automatic int nrOf(int keyBits);
        return keyBits / 32 + 6;
    endfunction

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmulNib(logic [7:0] a, logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] invMixColumn(logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmulNib(a0, 4'he) ^ gmulNib(a1, 4'hb) ^ gmulNib(a2, 4'hd) ^ gmulNib(a3, 4'h9),
                gmulNib(a0, 4'h9) ^ gmulNib(a1, 4'he) ^ gmulNib(a2, 4'hb) ^ gmulNib(a3, 4'hd),
                gmulNib(a0, 4'hd) ^ gmulNib(a1, 4'h9) ^ gmulNib(a2, 4'he) ^ gmulNib(a3, 4'hb),
                gmulNib(a0, 4'hb) ^ gmulNib(a1, 4'hd) ^ gmulNib(a2, 4'h9) ^ gmulNib(a3, 4'he)};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] subbed
);
    assign subbed = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
endmodule

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule, one word per clock, indexed round-key reads.
// Define AES_EQINV_KEY_EN to return InvMixColumns'd middle round keys in decryption order.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                busy,
    output logic                keys_valid,
    input  logic [3:0]          rd_round,
    input  logic                rd_inv,
    output logic [127:0]        rd_key
);
    localparam int NK = nkOf(KEY_BITS);
    localparam int NR = nrOf(KEY_BITS);
    localparam int TOTAL = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : gBadKeyBits
        $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
    end

    aesState_t state;
    logic [31:0] wordFile [TOTAL];
    logic [5:0] wordIdx;
    logic [2:0] modCnt;
    logic [7:0] rcon;
    logic [31:0] prevWord, subIn, subOut, temp, newWord;
    logic accept;

    assign key_ready = state != EXPAND;
    assign busy = state == EXPAND;
    assign keys_valid = state == DONE;
    assign accept = key_valid && key_ready;

    always_comb begin
        prevWord = wordFile[wordIdx - 6'd1];
        subIn = modCnt == 3'd0 ? {prevWord[23:0], prevWord[31:24]} : prevWord;
        temp = modCnt == 3'd0 ? subOut ^ {rcon, 24'h0} : (NK == 8 && modCnt == 3'd4) ? subOut : prevWord;
        newWord = wordFile[wordIdx - 6'(NK)] ^ temp;
    end

    aes_sub_word uSubWord (.word(subIn), .subbed(subOut));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            wordIdx <= '0;
            modCnt <= '0;
            rcon <= '0;
        end else if (accept) begin
            state <= EXPAND;
            wordIdx <= 6'(NK);
            modCnt <= '0;
            rcon <= 8'h01;
        end else if (state == EXPAND) begin
            wordIdx <= wordIdx + 6'd1;
            modCnt <= modCnt == 3'(NK - 1) ? 3'd0 : modCnt + 3'd1;
            if (modCnt == 3'd0) rcon <= xtime(rcon);
            if (wordIdx == 6'(TOTAL - 1)) state <= DONE;
        end

    // Each word is its own register so key words load in parallel while expanded words fill in order.
    for (genvar w = 0; w < TOTAL; w++) begin : gWord
        if (w < NK) begin : gKey
            always_ff @(posedge clk or negedge reset)
                if (!reset) wordFile[w] <= '0;
                else if (accept) wordFile[w] <= key_in[KEY_BITS-1-32*w -: 32];
        end else begin : gExp
            always_ff @(posedge clk or negedge reset)
                if (!reset) wordFile[w] <= '0;
                else if (state == EXPAND && wordIdx == 6'(w)) wordFile[w] <= newWord;
        end
    end

    logic [3:0] effRound;
    logic [5:0] base;
    logic [127:0] roundKey, outKey;

    always_comb begin
        effRound = rd_inv ? 4'(NR) - rd_round : rd_round;
        base = {effRound, 2'b00};
        roundKey = {wordFile[base], wordFile[base + 6'd1], wordFile[base + 6'd2], wordFile[base + 6'd3]};
`ifdef AES_EQINV_KEY_EN
        outKey = (rd_inv && effRound != 4'd0 && effRound != 4'(NR))
            ? {invMixColumn(roundKey[127:96]), invMixColumn(roundKey[95:64]),
               invMixColumn(roundKey[63:32]), invMixColumn(roundKey[31:0])}
            : roundKey;
`else
        outKey = roundKey;
`endif
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) rd_key <= '0;
        else rd_key <= rd_round > 4'(NR) ? 128'h0 : outKey;

endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed + random checks of all three key sizes against a reference key schedule.
module tb_aes_key_expander;
    logic clk = 0;
    logic reset = 0;
    always #5 clk = ~clk;

    logic [2:0][255:0] keyIn;
    logic [2:0] keyValid, keyReady, busy, keysValid, rdInv;
    logic [2:0][3:0] rdRound;
    logic [2:0][127:0] rdKey;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbT [256];
    logic [31:0] refW [3][60];

    aes_key_expander #(.KEY_BITS(128)) dut128 (.clk(clk), .reset(reset), .key_in(keyIn[0][127:0]),
        .key_valid(keyValid[0]), .key_ready(keyReady[0]), .busy(busy[0]), .keys_valid(keysValid[0]),
        .rd_round(rdRound[0]), .rd_inv(rdInv[0]), .rd_key(rdKey[0]));
    aes_key_expander #(.KEY_BITS(192)) dut192 (.clk(clk), .reset(reset), .key_in(keyIn[1][191:0]),
        .key_valid(keyValid[1]), .key_ready(keyReady[1]), .busy(busy[1]), .keys_valid(keysValid[1]),
        .rd_round(rdRound[1]), .rd_inv(rdInv[1]), .rd_key(rdKey[1]));
    aes_key_expander #(.KEY_BITS(256)) dut256 (.clk(clk), .reset(reset), .key_in(keyIn[2][255:0]),
        .key_valid(keyValid[2]), .key_ready(keyReady[2]), .busy(busy[2]), .keys_valid(keysValid[2]),
        .rd_round(rdRound[2]), .rd_inv(rdInv[2]), .rd_key(rdKey[2]));

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 0;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        logic [15:0] d = {v, v};
        d = d << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbT[w[31:24]], sbT[w[23:16]], sbT[w[15:8]], sbT[w[7:0]]};
    endfunction

    function automatic logic [31:0] invMix(logic [31:0] col);
        logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [31:0] o = 0;
        for (int row = 0; row < 4; row++)
            for (int c = 0; c < 4; c++)
                o[31-8*row -: 8] ^= gm(col[31-8*c -: 8], coef[(c - row + 4) % 4]);
        return o;
    endfunction

    // Straight FIPS-197 schedule, with i mod Nk computed directly.
    task automatic expand(int sel, logic [255:0] key);
        int nk = 4 + 2 * sel;
        int nr = nk + 6;
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) refW[sel][i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = refW[sel][i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) t = subw(t);
            refW[sel][i] = refW[sel][i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] expRound(int sel, int round, bit inv);
        int nr = 10 + 2 * sel;
        int r;
        logic [127:0] k;
        if (round > nr) return 128'h0;
        r = inv ? nr - round : round;
        k = {refW[sel][4*r], refW[sel][4*r+1], refW[sel][4*r+2], refW[sel][4*r+3]};
`ifdef AES_EQINV_KEY_EN
        if (inv && r > 0 && r < nr)
            for (int c = 0; c < 4; c++) k[127-32*c -: 32] = invMix(k[127-32*c -: 32]);
`endif
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(int sel, int round, bit inv, logic [127:0] exp);
        rdRound[sel] = 4'(round);
        rdInv[sel] = inv;
        step();
        chk($sformatf("rd s%0d r%0d i%0d", sel, round, inv), rdKey[sel], exp);
    endtask

    task automatic waitDone(int sel);
        int cycles = 0;
        while (!keysValid[sel] && cycles < 200) begin
            step();
            cycles++;
        end
        chk($sformatf("latency s%0d", sel), 128'(cycles), 128'(40 + 6 * sel));
        chk($sformatf("busy_done s%0d", sel), 128'(busy[sel]), 128'h0);
    endtask

    task automatic loadAndWait(int sel, logic [255:0] key);
        expand(sel, key);
        keyIn[sel] = key >> (128 - 64 * sel);
        keyValid[sel] = 1;
        step();
        keyValid[sel] = 0;
        chk($sformatf("busy_start s%0d", sel), 128'({busy[sel], keyReady[sel], keysValid[sel]}), 128'b100);
        waitDone(sel);
    endtask

    task automatic fullCheck(int sel);
        for (int r = 0; r < 16; r++)
            for (int inv = 0; inv < 2; inv++) rd(sel, r, inv[0], expRound(sel, r, inv[0]));
    endtask

    function automatic logic [255:0] rndKey();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom();
        return k;
    endfunction

    logic [255:0] k1, k2;

    initial begin
        keyIn = '0;
        keyValid = '0;
        rdRound = '0;
        rdInv = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 0;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbT[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        step();
        step();
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_flags s%0d", s), 128'({keyReady[s], busy[s], keysValid[s]}), 128'b100);
            chk($sformatf("reset_rdkey s%0d", s), rdKey[s], 128'h0);
        end
        reset = 1;
        step();

        loadAndWait(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        rd(0, 1, 0, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(0, 10, 0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(0, 0, 1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        fullCheck(0);
        loadAndWait(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
        rd(1, 12, 0, 128'he98ba06f448c773c8ecc720401002202);
        fullCheck(1);
        loadAndWait(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
        rd(2, 14, 0, 128'hfe4890d1e6188d0b046df344706c631e);
        fullCheck(2);

        for (int s = 0; s < 3; s++)
            for (int n = 0; n < 2; n++) begin
                loadAndWait(s, rndKey());
                fullCheck(s);
            end

        // key_valid held through expansion with a different key on the bus
        k1 = {rndKey()[255:128], 128'h0};
        k2 = {rndKey()[255:128], 128'h0};
        expand(0, k1);
        keyIn[0] = k1 >> 128;
        keyValid[0] = 1;
        step();
        keyIn[0] = k2 >> 128;
        for (int c = 0; c < 10; c++) step();
        chk("hold_ready", 128'({keyReady[0], busy[0]}), 128'b01);
        begin
            int cycles = 10;
            while (!keysValid[0] && cycles < 200) begin
                step();
                cycles++;
            end
            chk("hold_latency", 128'(cycles), 128'd40);
        end
        keyValid[0] = 0;
        fullCheck(0);
        loadAndWait(0, k2);
        fullCheck(0);

        // asynchronous reset mid-expansion
        keyIn[0] = rndKey() >> 128;
        keyValid[0] = 1;
        step();
        keyValid[0] = 0;
        for (int c = 0; c < 20; c++) step();
        reset = 0;
        #1;
        chk("midreset_flags", 128'({keyReady[0], busy[0], keysValid[0]}), 128'b100);
        step();
        chk("midreset_rdkey", rdKey[0], 128'h0);
        reset = 1;
        rd(0, 0, 0, 128'h0);
        rd(0, 5, 0, 128'h0);
        rd(2, 7, 0, 128'h0);

        loadAndWait(0, rndKey());
        rd(0, 11, 0, 128'h0);
        rd(0, 15, 1, 128'h0);
        rd(0, 4, 0, expRound(0, 4, 0));
        rd(1, 13, 1, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
